eem16_proj1: RTL and testbench

- Registered 3-input Boolean function block. Each cycle it samples x2,x1,x0 and drives z = F(x2,x1,x0).
- F is set by an 8-entry truth-table parameter; the default is 3-input majority.
- Small leaf block used as the first logic-evaluation stage in the project datapath. It also exposes a one-hot minterm decode and a pipeline-valid flag.

---
 rtl/eem16_proj1.sv | 85 ++++++++
 tb/tb_eem16_proj1.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/eem16_proj1.sv
// eem16_proj1 -- registered 3-input Boolean function block.
//
// Samples {x2,x1,x0} into an input register and, one edge later, drives z
// with TRUTH_TABLE[index]. minterm carries the one-hot decode of that same
// index. Total latency from the inputs to z/minterm is two rising edges.
// The x inputs have no combinational path to any output.
//
// Parameters:
//   TRUTH_TABLE  bit i is the value of z for minterm index i = {x2,x1,x0}
//                (default 8'b1110_1000 = 3-input majority)
//   RESET_Z      value of z while in reset and until valid rises
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous reset, active-high, wins over data updates
//   x0       in   function input, LSB of the minterm index
//   x1       in   function input, middle bit
//   x2       in   function input, MSB of the minterm index
//   z        out  registered function output
//   minterm  out  registered one-hot decode of the sampled index
//   valid    out  high once z/minterm reflect a post-reset sample
module eem16_proj1 #(
    parameter logic [7:0] TRUTH_TABLE = 8'b1110_1000,
    parameter logic       RESET_Z     = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       x0,
    input  logic       x1,
    input  logic       x2,
    output logic       z,
    output logic [7:0] minterm,
    output logic       valid
);

    // One-hot decode of a 3-bit minterm index.
    function automatic logic [7:0] decode_onehot(input logic [2:0] idx);
        logic [7:0] one_hot;
        one_hot = 8'b0000_0001 << idx;
        return one_hot;
    endfunction

    logic [2:0] x_r;     // stage-1 sampled index {x2,x1,x0}
    logic [1:0] fill_r;  // post-reset fill counter, saturates at 2

    // Stage 1: capture the function inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r <= 3'b000;
        end else begin
            x_r <= {x2, x1, x0};
        end
    end

    // Fill counter and valid flag: valid rises on the second non-reset edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_r <= 2'd0;
            valid  <= 1'b0;
        end else if (fill_r == 2'd2) begin
            fill_r <= 2'd2;
            valid  <= 1'b1;
        end else begin
            fill_r <= fill_r + 2'd1;
            valid  <= (fill_r == 2'd1);
        end
    end

    // Stage 2: evaluate the truth table and decode the sampled index.
    // While fill_r is still 0, x_r holds the reset value rather than a real
    // sample, so the outputs stay at their reset values until valid rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            z       <= RESET_Z;
            minterm <= 8'b0000_0000;
        end else if (fill_r == 2'd0) begin
            z       <= RESET_Z;
            minterm <= 8'b0000_0000;
        end else begin
            z       <= TRUTH_TABLE[x_r];
            minterm <= decode_onehot(x_r);
        end
    end

endmodule

// File: tb/tb_eem16_proj1.sv
// Self-checking bench for eem16_proj1. Three instances share the inputs:
//   dut_maj : default table (majority), RESET_Z = 0
//   dut_par : odd-parity table 8'b1001_0110
//   dut_rz1 : default table with RESET_Z = 1
// Each table row holds the inputs applied before an edge and the outputs
// expected just after that edge.
module tb_eem16_proj1;

    logic       clk;
    logic       rst;
    logic       x0;
    logic       x1;
    logic       x2;
    logic       z_maj;
    logic [7:0] m_maj;
    logic       v_maj;
    logic       z_par;
    logic [7:0] m_par;
    logic       v_par;
    logic       z_rz1;
    logic [7:0] m_rz1;
    logic       v_rz1;

    int n_pass;
    int n_total;

    eem16_proj1 dut_maj (
        .clk(clk), .rst(rst), .x0(x0), .x1(x1), .x2(x2),
        .z(z_maj), .minterm(m_maj), .valid(v_maj)
    );

    eem16_proj1 #(.TRUTH_TABLE(8'b1001_0110), .RESET_Z(1'b0)) dut_par (
        .clk(clk), .rst(rst), .x0(x0), .x1(x1), .x2(x2),
        .z(z_par), .minterm(m_par), .valid(v_par)
    );

    eem16_proj1 #(.TRUTH_TABLE(8'b1110_1000), .RESET_Z(1'b1)) dut_rz1 (
        .clk(clk), .rst(rst), .x0(x0), .x1(x1), .x2(x2),
        .z(z_rz1), .minterm(m_rz1), .valid(v_rz1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic       rst;
        logic [2:0] x;
        logic       z;    // expected z, majority table
        logic       zp;   // expected z, parity table
        logic [7:0] m;    // expected minterm
        logic       v;    // expected valid
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    task automatic check(input string name, input int step,
                         input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
        end
    endtask

    initial begin
        logic exp_z1;
        n_pass  = 0;
        n_total = 0;

        //            rst   x       z     zp    m             v
        // reset held for two edges
        vecs[0]  = '{1'b1, 3'b000, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 3'b000, 1'b0, 1'b0, 8'h00, 1'b0};
        // release, sweep 000..111 (outputs lag the inputs)
        vecs[2]  = '{1'b0, 3'b000, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[3]  = '{1'b0, 3'b001, 1'b0, 1'b0, 8'h01, 1'b1};
        vecs[4]  = '{1'b0, 3'b010, 1'b0, 1'b1, 8'h02, 1'b1};
        vecs[5]  = '{1'b0, 3'b011, 1'b0, 1'b1, 8'h04, 1'b1};
        vecs[6]  = '{1'b0, 3'b100, 1'b1, 1'b0, 8'h08, 1'b1};
        vecs[7]  = '{1'b0, 3'b101, 1'b0, 1'b1, 8'h10, 1'b1};
        vecs[8]  = '{1'b0, 3'b110, 1'b1, 1'b0, 8'h20, 1'b1};
        vecs[9]  = '{1'b0, 3'b111, 1'b1, 1'b0, 8'h40, 1'b1};
        // return to zero
        vecs[10] = '{1'b0, 3'b000, 1'b1, 1'b1, 8'h80, 1'b1};
        vecs[11] = '{1'b0, 3'b000, 1'b0, 1'b0, 8'h01, 1'b1};
        // mid-stream reset for one edge at x=110
        vecs[12] = '{1'b0, 3'b001, 1'b0, 1'b0, 8'h01, 1'b1};
        vecs[13] = '{1'b1, 3'b110, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[14] = '{1'b0, 3'b010, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[15] = '{1'b0, 3'b011, 1'b0, 1'b1, 8'h04, 1'b1};
        // back-to-back toggling 011 / 100
        vecs[16] = '{1'b0, 3'b100, 1'b1, 1'b0, 8'h08, 1'b1};
        vecs[17] = '{1'b0, 3'b011, 1'b0, 1'b1, 8'h10, 1'b1};
        vecs[18] = '{1'b0, 3'b100, 1'b1, 1'b0, 8'h08, 1'b1};
        vecs[19] = '{1'b0, 3'b011, 1'b0, 1'b1, 8'h10, 1'b1};
        vecs[20] = '{1'b0, 3'b000, 1'b1, 1'b0, 8'h08, 1'b1};

        rst = 1'b1;
        {x2, x1, x0} = 3'b000;

        for (int i = 0; i < NVEC; i++) begin
            rst          = vecs[i].rst;
            {x2, x1, x0} = vecs[i].x;
            @(posedge clk);
            #1;
            // RESET_Z=1 instance shows 1 whenever valid is expected low
            exp_z1 = vecs[i].v ? vecs[i].z : 1'b1;
            check("maj_z",       i, {7'b0, z_maj}, {7'b0, vecs[i].z});
            check("maj_minterm", i, m_maj,         vecs[i].m);
            check("maj_valid",   i, {7'b0, v_maj}, {7'b0, vecs[i].v});
            check("par_z",       i, {7'b0, z_par}, {7'b0, vecs[i].zp});
            check("par_minterm", i, m_par,         vecs[i].m);
            check("rz1_z",       i, {7'b0, z_rz1}, {7'b0, exp_z1});
            check("rz1_valid",   i, {7'b0, v_rz1}, {7'b0, vecs[i].v});
            #3;
        end

        // Hand sequence: inputs changed between edges must not reach outputs.
        rst          = 1'b0;
        {x2, x1, x0} = 3'b111;
        #2;
        check("no_comb_path_z", NVEC, {7'b0, z_maj}, {7'b0, 1'b1});
        check("no_comb_path_m", NVEC, m_maj,         8'h08);
        @(posedge clk);
        #1;
        // edge took x=111; outputs now show the 000 sample
        check("lag_z", NVEC + 1, {7'b0, z_maj}, {7'b0, 1'b0});
        check("lag_m", NVEC + 1, m_maj,         8'h01);
        {x2, x1, x0} = 3'b000;
        @(posedge clk);
        #1;
        check("lag2_z", NVEC + 2, {7'b0, z_maj}, {7'b0, 1'b1});
        check("lag2_m", NVEC + 2, m_maj,         8'h80);
        check("lag2_par", NVEC + 2, {7'b0, z_par}, {7'b0, 1'b1});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
